sample_delta_detector: RTL and testbench
========================================

Name: sample_delta_detector

Overview:
Downstream consumer of the signed 4-bit sample stream produced by the previous-value stage. It holds the last accepted sample and emits a registered signed delta (current − previous) for each new sample. It also flags rising/falling steps beyond a threshold and counts zero crossings, with a hold-off that debounces chatter around zero. Its outputs feed the display/LED status logic.

Parameters:
WIDTH, 4, sample width in bits (signed two's complement)
THRESH, 2, minimum |delta| for a rising/falling flag (1..2^WIDTH−1)
HOLDOFF, 2, accepted samples after a counted crossing during which further crossings are ignored (0 disables)
CNT_WIDTH, 8, width of the saturating crossing counter

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous counter clear; does not disturb stored sample or state
in_valid  in  1  in_sample is accepted on this cycle
in_sample  in  WIDTH  signed input sample
out_valid  out  1  one-cycle pulse; out_* fields valid on this cycle
out_delta  out  WIDTH+1  signed in_sample − previous sample
out_rising  out  1  out_delta >= THRESH (qualified by out_valid)
out_falling  out  1  out_delta <= −THRESH (qualified by out_valid)
zero_cross  out  1  counted sign crossing on this output (qualified by out_valid)
cross_count  out  CNT_WIDTH  saturating count of counted crossings
primed  out  1  a previous sample is held (state != EMPTY)

Behaviour:
- Reset: state=EMPTY; prev=0; holdoff counter=0; out_valid, out_rising, out_falling, zero_cross, primed = 0; out_delta=0; cross_count=0.
- States: EMPTY (no previous sample), RUN (crossings counted), HOLD (crossings suppressed).
- EMPTY + in_valid: store sample as prev, go to RUN, primed=1 next cycle, no output pulse.
- RUN/HOLD + in_valid: delta = sext(in_sample) − sext(prev) in WIDTH+1 bits, never overflows (range −15..+15 for WIDTH=4). Registered outputs appear the cycle after acceptance, so latency is 1 and out_valid pulses for exactly one cycle. prev <= in_sample.
- in_valid may be high on consecutive cycles; every cycle is an accepted sample and produces back-to-back out_valid pulses. There is no backpressure.
- Sign class: negative if MSB=1, otherwise non-negative (zero counts as non-negative).
- Crossing: the sign class of prev differs from the sign class of in_sample.
- RUN: a crossing sets zero_cross=1 and cross_count += 1 (saturating at 2^CNT_WIDTH−1). If HOLDOFF>0, load the counter with HOLDOFF and go to HOLD.
- HOLD: each accepted sample decrements the counter. Crossings in HOLD give zero_cross=0 and are not counted. When the counter reaches 0 on an accepted sample, go to RUN; that same sample is still in HOLD.
- out_rising/out_falling are evaluated in every non-EMPTY state, independent of HOLD. They are mutually exclusive.
- Cycles without in_valid: no state change, no pulse, holdoff frozen.
- clear: cross_count <= 0 next cycle. If clear and a counted crossing land on the same cycle, clear wins (count=0) but zero_cross still pulses.
- rst has priority over everything. Mid-stream rst discards prev and any pending output (no out_valid the cycle after rst); the next sample only re-primes.
- Non-valid cycles: out_delta/out_rising/out_falling/zero_cross hold their last values, and are don't-care when out_valid=0.

Test Plan:
- Priming: rst, then samples 3, 3 -> no pulse after the first; after the second, out_valid=1, out_delta=0, rising=falling=zero_cross=0, primed=1.
- Extremes: −8 then 7 -> out_delta=+15, rising=1, zero_cross=1, cross_count=1. Next 7 then −8 -> out_delta=−15, falling=1.
- Threshold edge (THRESH=2): 0,1,3,1 -> deltas +1,+2,−2, flags none, rising, falling. 0 to 1 is not a crossing.
- Hold-off (HOLDOFF=2): 1,−1,1,−1,1 back-to-back -> zero_cross only on −1 (first) and the 5th sample; cross_count ends at 2.
- Saturation/clear (CNT_WIDTH=2): 6 alternating crossings with HOLDOFF=0 -> count sticks at 3. Assert clear on a crossing cycle -> count=0, zero_cross=1.
- Mid-stream reset: stream 2,−3, assert rst on the −3 accept cycle -> no out_valid follows, primed=0. Then 5,4 -> single pulse with out_delta=−1.

Source files
------------

// File: rtl/sample_delta_detector.sv
// Tracks the last accepted signed sample and emits a registered delta with step flags,
// plus a debounced, saturating zero-crossing counter for the status/LED logic.
module sample_delta_detector #(
  parameter int WIDTH     = 4,
  parameter int THRESH    = 2,
  parameter int HOLDOFF   = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_sample,
  output logic                 out_valid,
  output logic [WIDTH:0]       out_delta,
  output logic                 out_rising,
  output logic                 out_falling,
  output logic                 zero_cross,
  output logic [CNT_WIDTH-1:0] cross_count,
  output logic                 primed
);

  localparam int HCW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic signed [WIDTH+1:0] THR_POS = (WIDTH + 2)'(THRESH);
  localparam logic signed [WIDTH+1:0] THR_NEG = -THR_POS;

  typedef enum logic [1:0] {EMPTY, RUN, HOLD} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] prev_q;
  logic [HCW-1:0]          hcnt;

  logic signed [WIDTH-1:0] samp_p0;
  logic signed [WIDTH:0]   delta_p0;
  logic signed [WIDTH+1:0] delta_x_p0;
  logic                    cross_p0;
  logic                    rise_p0;
  logic                    fall_p0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage p0: combinational delta and classification of the incoming sample
  assign samp_p0    = $signed(in_sample);
  assign delta_p0   = (WIDTH + 1)'(samp_p0) - (WIDTH + 1)'(prev_q);
  assign delta_x_p0 = (WIDTH + 2)'(delta_p0);
  assign cross_p0   = samp_p0[WIDTH-1] ^ prev_q[WIDTH-1];
  assign rise_p0    = (delta_x_p0 >= THR_POS);
  assign fall_p0    = (delta_x_p0 <= THR_NEG);

  // Stage p1: registered outputs, sample history and crossing state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      prev_q      <= '0;
      hcnt        <= '0;
      out_valid   <= 1'b0;
      out_delta   <= '0;
      out_rising  <= 1'b0;
      out_falling <= 1'b0;
      zero_cross  <= 1'b0;
      cross_count <= '0;
      primed      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        prev_q <= samp_p0;
        unique case (state)
          EMPTY: begin
            state  <= RUN;
            primed <= 1'b1;
          end
          default: begin
            out_valid   <= 1'b1;
            out_delta   <= delta_p0;
            out_rising  <= rise_p0;
            out_falling <= fall_p0;
            if (state == RUN) begin
              zero_cross <= cross_p0;
              if (cross_p0) begin
                cross_count <= sat_inc(cross_count);
                if (HOLDOFF > 0) begin
                  hcnt  <= HCW'(HOLDOFF);
                  state <= HOLD;
                end
              end
            end else begin
              // Suppressed window: the sample that empties the counter is still suppressed
              zero_cross <= 1'b0;
              hcnt       <= hcnt - 1'b1;
              if (hcnt == HCW'(1)) state <= RUN;
            end
          end
        endcase
      end
      if (clear) cross_count <= '0;
    end
  end

endmodule

// File: tb/tb_sample_delta_detector.sv
// Bench for sample_delta_detector: directed vector table, a saturation/clear sequence
// on a small-counter instance, and randomized traffic against a behavioural model.
module tb_sample_delta_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_sample = '0;

  logic       out_valid, out_rising, out_falling, zero_cross, primed;
  logic [4:0] out_delta;
  logic [7:0] cross_count;

  logic       s_valid, s_rising, s_falling, s_zc, s_primed;
  logic [4:0] s_delta;
  logic [1:0] s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_delta_detector #(.WIDTH(4), .THRESH(2), .HOLDOFF(2), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(out_valid), .out_delta(out_delta), .out_rising(out_rising),
    .out_falling(out_falling), .zero_cross(zero_cross), .cross_count(cross_count),
    .primed(primed)
  );

  sample_delta_detector #(.WIDTH(4), .THRESH(2), .HOLDOFF(0), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(s_valid), .out_delta(s_delta), .out_rising(s_rising),
    .out_falling(s_falling), .zero_cross(s_zc), .cross_count(s_count),
    .primed(s_primed)
  );

  typedef struct {
    int r, c, v, s;
    int ev, ed, er, ef, ez, cnt, p;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int c, int v, int s, int ev, int ed, int er,
                              int ef, int ez, int cnt, int p);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.s = s;
    t.ev = ev; t.ed = ed; t.er = er; t.ef = ef; t.ez = ez; t.cnt = cnt; t.p = p;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int r, input int c, input int v, input int s);
    rst       = 1'(r);
    clear     = 1'(c);
    in_valid  = 1'(v);
    in_sample = 4'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input int idx, input int ev, input int ed,
                            input int er, input int ef, input int ez, input int cnt, input int p);
    chk({tag, ".valid"}, idx, int'(out_valid), ev);
    chk({tag, ".count"}, idx, int'(cross_count), cnt);
    chk({tag, ".primed"}, idx, int'(primed), p);
    if (ev != 0) begin
      chk({tag, ".delta"}, idx, int'($signed(out_delta)), ed);
      chk({tag, ".rising"}, idx, int'(out_rising), er);
      chk({tag, ".falling"}, idx, int'(out_falling), ef);
      chk({tag, ".zero_cross"}, idx, int'(zero_cross), ez);
    end
  endtask

  // Behavioural reference for the main instance (HOLDOFF=2, THRESH=2, 8-bit count)
  int m_have, m_prev, m_supp, m_cnt;
  int m_ev, m_ed, m_er, m_ef, m_ez;

  task automatic model_step(input int r, input int c, input int v, input int s);
    int d;
    m_ev = 0;
    if (r != 0) begin
      m_have = 0; m_prev = 0; m_supp = 0; m_cnt = 0;
      return;
    end
    if (v != 0) begin
      if (m_have == 0) begin
        m_have = 1;
      end else begin
        d = s - m_prev;
        m_ev = 1; m_ed = d;
        m_er = (d >= 2) ? 1 : 0;
        m_ef = (d <= -2) ? 1 : 0;
        if (m_supp > 0) begin
          m_supp--;
          m_ez = 0;
        end else begin
          m_ez = ((s < 0) != (m_prev < 0)) ? 1 : 0;
          if (m_ez != 0) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_supp = 2;
          end
        end
      end
      m_prev = s;
    end
    if (c != 0) m_cnt = 0;
  endtask

  initial begin
    // reset and priming
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,3,   0,0,0,0,0, 0,1));
    tbl.push_back(mk(0,0,1,3,   1,0,0,0,0, 0,1));
    tbl.push_back(mk(0,0,0,0,   0,0,0,0,0, 0,1));
    // extremes
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,-8,  0,0,0,0,0, 0,1));
    tbl.push_back(mk(0,0,1,7,   1,15,1,0,1, 1,1));
    tbl.push_back(mk(0,0,1,7,   1,0,0,0,0, 1,1));
    tbl.push_back(mk(0,0,1,-8,  1,-15,0,1,0, 1,1));
    // threshold edge
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,0,   0,0,0,0,0, 0,1));
    tbl.push_back(mk(0,0,1,1,   1,1,0,0,0, 0,1));
    tbl.push_back(mk(0,0,1,3,   1,2,1,0,0, 0,1));
    tbl.push_back(mk(0,0,1,1,   1,-2,0,1,0, 0,1));
    // hold-off, back-to-back
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,1,   0,0,0,0,0, 0,1));
    tbl.push_back(mk(0,0,1,-1,  1,-2,0,1,1, 1,1));
    tbl.push_back(mk(0,0,1,1,   1,2,1,0,0, 1,1));
    tbl.push_back(mk(0,0,1,-1,  1,-2,0,1,0, 1,1));
    tbl.push_back(mk(0,0,1,1,   1,2,1,0,1, 2,1));
    tbl.push_back(mk(0,1,0,0,   0,0,0,0,0, 0,1));
    // mid-stream reset
    tbl.push_back(mk(1,0,0,0,   0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,2,   0,0,0,0,0, 0,1));
    tbl.push_back(mk(1,0,1,-3,  0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,5,   0,0,0,0,0, 0,1));
    tbl.push_back(mk(0,0,1,4,   1,-1,0,0,0, 0,1));
    tbl.push_back(mk(0,0,0,0,   0,0,0,0,0, 0,1));

    drive(1, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].s);
      check_main("vec", i, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ef,
                 tbl[i].ez, tbl[i].cnt, tbl[i].p);
    end

    // saturation and clear on the 2-bit counter, no hold-off
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 1);
    chk("sat.primed", 0, int'(s_primed), 1);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, (i % 2 == 0) ? -1 : 1);
      chk("sat.valid", i, int'(s_valid), 1);
      chk("sat.zero_cross", i, int'(s_zc), 1);
      chk("sat.count", i, int'(s_count), (i + 1 < 3) ? i + 1 : 3);
    end
    drive(0, 1, 1, -1);
    chk("clr.valid", 0, int'(s_valid), 1);
    chk("clr.zero_cross", 0, int'(s_zc), 1);
    chk("clr.count", 0, int'(s_count), 0);
    chk("clr.delta", 0, int'($signed(s_delta)), -2);

    // randomized traffic against the model
    drive(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      int r, c, v, s;
      r = ($urandom_range(0, 59) == 0) ? 1 : 0;
      c = ($urandom_range(0, 24) == 0) ? 1 : 0;
      v = ($urandom_range(0, 9) < 7) ? 1 : 0;
      s = int'($urandom_range(0, 15)) - 8;
      drive(r, c, v, s);
      model_step(r, c, v, s);
      check_main("rnd", n, m_ev, m_ed, m_er, m_ef, m_ez, m_cnt, m_have);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
